spram_req_ctrl: RTL and testbench

- Request/response front end for the single-port RAM wrapper. Sits directly upstream of it and also consumes its read data.
- Accepts valid/ready read and write requests from a cache or TLB-storage client and drives the RAM en/we/addr/din pins.
- Tracks reads in flight across the RAM's fixed read latency and captures each returned word into a small response FIFO.
- A stalled consumer therefore never loses read data; the RAM itself has no output hold.

---
 rtl/spram_pkg.sv | 17 +
 rtl/spram_req_ctrl_if.sv | 28 ++
 rtl/spram_resp_fifo.sv | 61 ++++++
 rtl/spram_req_ctrl.sv | 113 +++++++++++
 tb/tb_spram_req_ctrl.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/spram_pkg.sv
// rtl/spram_pkg.sv - shared defaults and width helpers for spram_req_ctrl
package spram_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_DEPTH      = 128;
    localparam int DEF_LATENCY    = 1;

    function automatic int clog2_min1(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Counter width able to hold 0..entries inclusive.
    function automatic int count_width(input int entries);
        return clog2_min1(entries + 1);
    endfunction

endpackage

// File: rtl/spram_req_ctrl_if.sv
// rtl/spram_req_ctrl_if.sv - client request/response handshake bundle for spram_req_ctrl
interface spram_req_ctrl_if
    import spram_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = clog2_min1(DEF_DEPTH)
) ();

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata
    );

endinterface

// File: rtl/spram_resp_fifo.sv
// rtl/spram_resp_fifo.sv - first-word-fall-through response FIFO with async active-low reset
module spram_resp_fifo
    import spram_pkg::*;
#(
    parameter  int WIDTH = DEF_DATA_WIDTH,
    parameter  int DEPTH = 2,
    localparam int PW    = clog2_min1(DEPTH),
    localparam int CW    = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && !full;
    // Head reads as zero when empty so the response bus is quiet out of reset.
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assert property (@(posedge clk) disable iff (!resetn) !(push && full))
        else $error("spram_resp_fifo: push while full");

endmodule

// File: rtl/spram_req_ctrl.sv
// rtl/spram_req_ctrl.sv - credit-based SPRAM request front end; SPRAM_REQ_CTRL_WRITE_ACK_EN adds write acks
module spram_req_ctrl
    import spram_pkg::*;
#(
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int DEPTH      = DEF_DEPTH,
    parameter  int LATENCY    = DEF_LATENCY,
    parameter  int RESP_DEPTH = LATENCY + 1,
    localparam int AW         = clog2_min1(DEPTH),
    localparam int CW         = count_width(RESP_DEPTH)
) (
    input  logic                  clk,
    input  logic                  resetn,
    spram_req_ctrl_if.slave       bus,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [AW-1:0]         ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    logic [CW-1:0]         credits;
    logic                  accept;
    logic                  takes_credit;
    logic                  pop;
    logic                  push;
    logic [LATENCY-1:0]    vpipe;
    logic [DATA_WIDTH-1:0] push_data;
    logic [AW-1:0]         addr_q;
    logic [DATA_WIDTH-1:0] din_q;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [CW-1:0]         fifo_count;

    assign bus.req_ready  = (credits != '0);
    assign accept         = bus.req_valid && bus.req_ready;
    assign bus.resp_valid = !fifo_empty;
    assign pop            = bus.resp_valid && bus.resp_ready;

`ifdef SPRAM_REQ_CTRL_WRITE_ACK_EN
    assign takes_credit = accept;
`else
    assign takes_credit = accept && !bus.req_we;
`endif

    // RAM pins follow the request combinationally; address/data hold when idle.
    assign ram_en   = accept;
    assign ram_we   = accept && bus.req_we;
    assign ram_addr = accept ? bus.req_addr  : addr_q;
    assign ram_din  = accept ? bus.req_wdata : din_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            credits <= CW'(RESP_DEPTH);
            vpipe   <= '0;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            case ({takes_credit, pop})
                2'b10:   credits <= credits - 1'b1;
                2'b01:   credits <= credits + 1'b1;
                default: ;
            endcase
            vpipe <= (vpipe << 1) | LATENCY'(takes_credit);
            if (accept) begin
                addr_q <= bus.req_addr;
                din_q  <= bus.req_wdata;
            end
        end
    end

    assign push = vpipe[LATENCY-1];

`ifdef SPRAM_REQ_CTRL_WRITE_ACK_EN
    logic [LATENCY-1:0]    tpipe;
    logic [DATA_WIDTH-1:0] dpipe [LATENCY];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) tpipe <= '0;
        else         tpipe <= (tpipe << 1) | LATENCY'(accept && bus.req_we);
    end

    always_ff @(posedge clk) begin
        dpipe[0] <= bus.req_wdata;
        for (int i = 1; i < LATENCY; i++) dpipe[i] <= dpipe[i-1];
    end

    // A tagged exit is a write ack: return the captured write data, not RAM output.
    assign push_data = tpipe[LATENCY-1] ? dpipe[LATENCY-1] : ram_dout;
`else
    assign push_data = ram_dout;
`endif

    spram_resp_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RESP_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .din    (push_data),
        .pop    (pop),
        .dout   (bus.resp_rdata),
        .empty  (fifo_empty),
        .full   (fifo_full),
        .count  (fifo_count)
    );

    assert property (@(posedge clk) disable iff (!resetn)
                     (int'(fifo_count) + int'(credits) <= RESP_DEPTH) && (!fifo_full || credits == '0))
        else $error("spram_req_ctrl: credit accounting broken");

endmodule

// File: tb/tb_spram_req_ctrl.sv
// tb/tb_spram_req_ctrl.sv - directed and random self-checking bench for spram_req_ctrl
module tb_spram_req_ctrl;
    import spram_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 128;
    localparam int AW    = 7;
    localparam int LAT   = 2;
    localparam int RD    = 3;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    spram_req_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    spram_req_ctrl #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .LATENCY    (LAT),
        .RESP_DEPTH (RD)
    ) u_dut (
        .clk      (clk),
        .resetn   (resetn),
        .bus      (bus),
        .ram_en   (ram_en),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    // Single-port RAM with LAT-cycle registered read.
    logic [DW-1:0] ram_mem [DEPTH] = '{default: '0};
    logic [DW-1:0] rd_pipe [LAT]   = '{default: '0};
    always @(posedge clk) begin
        if (ram_en && ram_we)  ram_mem[ram_addr] <= ram_din;
        if (ram_en && !ram_we) rd_pipe[0] <= ram_mem[ram_addr];
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_dout = rd_pipe[LAT-1];

    int            n_checks = 0;
    int            n_pass   = 0;
    int            cyc_n    = 0;
    logic          last_acc;
    logic          last_pop;
    logic [DW-1:0] last_rdata;
    logic [DW-1:0] ref_mem [DEPTH] = '{default: '0};
    logic [DW-1:0] exp_q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One clock: drive at negedge, evaluate the handshake before the next posedge.
    task automatic cyc(input logic v, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic rr);
        @(negedge clk);
        bus.req_valid  = v;
        bus.req_we     = we;
        bus.req_addr   = a;
        bus.req_wdata  = d;
        bus.resp_ready = rr;
        #1;
        cyc_n++;
        last_acc = v && bus.req_ready;
        last_pop = bus.resp_valid && rr;
        if (last_acc) begin
            if (we) begin
                ref_mem[a] = d;
`ifdef SPRAM_REQ_CTRL_WRITE_ACK_EN
                exp_q.push_back(d);
`endif
            end else begin
                exp_q.push_back(ref_mem[a]);
            end
        end
        if (last_pop) begin
            last_rdata = bus.resp_rdata;
            if (exp_q.size() == 0) check("resp_unexpected", bus.resp_valid, 0);
            else                   check("resp_data", bus.resp_rdata, exp_q.pop_front());
        end
    endtask

    task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic rr);
        int n = 0;
        do begin
            cyc(1'b1, we, a, d, rr);
            n++;
        end while (!last_acc && n < 50);
        if (!last_acc) check("send_timeout", last_acc, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, '0, '0, 1'b1);
    endtask

    initial begin
        int nxt, t0, first, nresp, acc_n;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        check("rst_req_ready",  bus.req_ready, 1);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_resp_rdata", bus.resp_rdata, 0);
        check("rst_ram_en",     ram_en, 0);
        check("rst_ram_we",     ram_we, 0);
        check("rst_ram_addr",   ram_addr, 0);
        check("rst_ram_din",    ram_din, 0);
        check("rst_credits",    u_dut.credits, RD);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 8; i++) send(1'b1, AW'(i), DW'(32'hA000 + i), 1'b1);
        idle(8);

        // RAM pins during an accepted write, then hold while idle.
        cyc(1'b1, 1'b1, 7'h20, 32'h1234_5678, 1'b1);
        check("wr_accept",   last_acc, 1);
        check("wr_ram_en",   ram_en, 1);
        check("wr_ram_we",   ram_we, 1);
        check("wr_ram_addr", ram_addr, 7'h20);
        check("wr_ram_din",  ram_din, 32'h1234_5678);
        cyc(1'b0, 1'b0, 7'h33, 32'h0, 1'b1);
        check("idle_ram_en",   ram_en, 0);
        check("idle_ram_we",   ram_we, 0);
        check("idle_ram_addr", ram_addr, 7'h20);
        check("idle_ram_din",  ram_din, 32'h1234_5678);
        idle(6);

        // Back-to-back reads of 0..7.
        nxt = 0; t0 = 0; first = 0; nresp = 0;
        for (int c = 0; c < 40; c++) begin
            cyc(nxt < 8, 1'b0, AW'(nxt), '0, 1'b1);
            if (last_acc) begin
                if (nxt == 0) t0 = cyc_n;
                nxt++;
            end
            if (last_pop) begin
                if (nresp == 0) first = cyc_n;
                nresp++;
            end
        end
        check("b2b_first_latency", first - t0, LAT + 1);
        check("b2b_resp_count",    nresp, 8);
        check("b2b_drained",       exp_q.size(), 0);

        // Backpressure: consumer stalled, 5 reads offered.
        nxt = 0;
        for (int c = 0; c < 8; c++) begin
            cyc(nxt < 5, 1'b0, AW'(nxt), '0, 1'b0);
            if (last_acc) nxt++;
        end
        check("bp_accepted",    nxt, 3);
        check("bp_req_ready",   bus.req_ready, 0);
        check("bp_credits",     u_dut.credits, 0);
        check("bp_fifo_count",  u_dut.u_fifo.count, RD);
        check("bp_resp_valid",  bus.resp_valid, 1);
        check("bp_head",        bus.resp_rdata, 32'hA000);
        cyc(1'b1, 1'b0, AW'(nxt), '0, 1'b1);
        check("bp_ready_at_pop", last_acc, 0);
        cyc(1'b1, 1'b0, AW'(nxt), '0, 1'b1);
        check("bp_ready_after_pop", last_acc, 1);
        if (last_acc) nxt++;
        cyc(nxt < 5, 1'b0, AW'(nxt), '0, 1'b1);
        check("bp_credits_pop_accept", u_dut.credits, 1);
        if (last_acc) nxt++;
        for (int c = 0; c < 20; c++) begin
            cyc(nxt < 5, 1'b0, AW'(nxt), '0, 1'b1);
            if (last_acc) nxt++;
        end
        check("bp_all_accepted", nxt, 5);
        check("bp_drained",      exp_q.size(), 0);

        // Read-after-write on consecutive cycles.
        send(1'b1, 7'h10, 32'hDEAD_BEEF, 1'b1);
        cyc(1'b1, 1'b0, 7'h10, '0, 1'b1);
        check("raw_read_accept", last_acc, 1);
        nresp = 0;
        for (int c = 0; c < 10; c++) begin
            cyc(1'b0, 1'b0, '0, '0, 1'b1);
            if (last_pop) begin
                nresp++;
                check("raw_data", last_rdata, 32'hDEAD_BEEF);
            end
        end
`ifdef SPRAM_REQ_CTRL_WRITE_ACK_EN
        check("raw_resp_count", nresp, 2);
`else
        check("raw_resp_count", nresp, 1);
`endif

        // Reset with two reads in flight.
        cyc(1'b1, 1'b0, 7'h05, '0, 1'b1);
        cyc(1'b1, 1'b0, 7'h06, '0, 1'b1);
        @(negedge clk);
        resetn        = 1'b0;
        bus.req_valid = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_resp_valid", bus.resp_valid, 0);
        check("midrst_req_ready",  bus.req_ready, 1);
        check("midrst_credits",    u_dut.credits, RD);
        @(negedge clk);
        resetn = 1'b1;
        nresp = 0;
        for (int c = 0; c < 8; c++) begin
            cyc(1'b0, 1'b0, '0, '0, 1'b1);
            if (last_pop) nresp++;
        end
        check("midrst_no_resp", nresp, 0);

        // Random mixed traffic against the reference memory.
        acc_n = 0;
        for (int c = 0; c < 60000 && acc_n < 10000; c++) begin
            cyc($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
                $urandom, $urandom_range(0, 3) != 0);
            if (last_acc) acc_n++;
        end
        idle(20);
        check("rand_accepted", acc_n, 10000);
        check("rand_drained",  exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
